// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Drains NUM_FIFOS first-word-fall-through input FIFOs into one shared
//   output FIFO, at most one word per clock. Arbitration is round-robin.
//   Popping stops while the output FIFO signals almost-full. The block also
//   latches the almost-full threshold during INIT and drives it to the FIFOs.
//
// Build option:
//   ARB_STRICT_PRIO_EN  defined   -> lowest eligible index always wins and
//                                    the round-robin pointer is tied to 0.
//                       undefined -> round-robin from rr_ptr (default).
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   init             configuration request; thr_in is sampled while in INIT
//   thr_in           almost-full threshold to latch
//   fifo_empty       per-FIFO empty flags
//   fifo_data        head words; FIFO i at [i*BITNUMBER +: BITNUMBER]
//   out_almost_full  back-pressure from the output FIFO
//   fifo_rd          one-hot pop strobes (combinational)
//   out_wr           push strobe to the output FIFO (registered)
//   out_data         word to push (registered, holds when out_wr=0)
//   thr_out          latched threshold
//   state            FSM state: RESET=00 INIT=01 IDLE=10 ACTIVE=11
//   idle             high while state is IDLE

module fifo_rr_arbiter #(
  parameter int BITNUMBER = 8,
  parameter int NUM_FIFOS = 4,
  parameter int THR_W     = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic [THR_W-1:0]               thr_in,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS*BITNUMBER-1:0] fifo_data,
  input  logic                           out_almost_full,
  output logic [NUM_FIFOS-1:0]           fifo_rd,
  output logic                           out_wr,
  output logic [BITNUMBER-1:0]           out_data,
  output logic [THR_W-1:0]               thr_out,
  output logic [1:0]                     state,
  output logic                           idle
);

  localparam int PTR_W = $clog2(NUM_FIFOS);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } st_t;

  st_t                                st;
  logic                               can_pop;
  logic [NUM_FIFOS-1:0]               elig;
  logic [NUM_FIFOS-1:0][BITNUMBER-1:0] lane_data;
  logic [BITNUMBER-1:0]               mux_data;
  logic [PTR_W-1:0]                   rr_ptr;
  logic [PTR_W-1:0]                   grant_idx;
  logic                               grant_vld;
  logic                               pop;

  assign state = st;
  assign idle  = (st == ST_IDLE);

  // init gates popping in the same cycle so a configuration request never
  // races a transfer; a word popped on the previous edge still writes.
  assign can_pop = (st == ST_ACTIVE) & ~out_almost_full & ~init;

  // Per-lane eligibility, pop strobe and AND-masked head word. Because
  // fifo_rd is one-hot, OR-ing the masked words forms the data mux.
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_lane
    assign elig[i]      = can_pop & ~fifo_empty[i];
    assign fifo_rd[i]   = grant_vld & (grant_idx == PTR_W'(i));
    assign lane_data[i] = {BITNUMBER{fifo_rd[i]}} & fifo_data[i*BITNUMBER +: BITNUMBER];
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_FIFOS; i++) mux_data = mux_data | lane_data[i];
  end

  // First eligible index at or above rr_ptr, wrapping to 0.
  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_FIFOS) j = j - NUM_FIFOS;
      if (!grant_vld && elig[j[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = j[PTR_W-1:0];
      end
    end
  end

  assign pop = grant_vld;

`ifdef ARB_STRICT_PRIO_EN
  // Fixed priority: search always starts at FIFO 0.
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (grant_vld)
      rr_ptr <= (grant_idx == PTR_W'(NUM_FIFOS-1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_RESET;
      thr_out <= '0;
    end else begin
      case (st)
        ST_RESET: st <= ST_INIT;
        ST_INIT: begin
          thr_out <= thr_in;
          if (!init) st <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)              st <= ST_INIT;
          else if (!(&fifo_empty)) st <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                        st <= ST_INIT;
          else if ((&fifo_empty) && !pop)  st <= ST_IDLE;
        end
        default: st <= ST_RESET;
      endcase
    end
  end

  // One-stage data pipe: popped word lands in out_data on the pop edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
    end else begin
      out_wr <= pop;
      if (pop) out_data <= mux_data;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;
  localparam int BW = 8, NF = 4, TW = 3;
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              init = 1'b0;
  logic [TW-1:0]     thr_in = '0;
  logic [NF-1:0]     fifo_empty = '1;
  logic [NF*BW-1:0]  fifo_data = '0;
  logic              af = 1'b0;
  logic [NF-1:0]     fifo_rd;
  logic              out_wr;
  logic [BW-1:0]     out_data;
  logic [TW-1:0]     thr_out;
  logic [1:0]        state;
  logic              idle;

  fifo_rr_arbiter #(.BITNUMBER(BW), .NUM_FIFOS(NF), .THR_W(TW)) dut (
    .clk(clk), .reset(reset), .init(init), .thr_in(thr_in),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .out_almost_full(af),
    .fifo_rd(fifo_rd), .out_wr(out_wr), .out_data(out_data),
    .thr_out(thr_out), .state(state), .idle(idle)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Input FIFO contents (environment) and reference model state.
  logic [7:0] fm [NF][32];
  int         fc [NF];
  int         mstate, mptr, mgrant;
  logic       mwr;
  logic [7:0] mdata;
  logic [TW-1:0] mthr;
  int         run, maxrun;
  int         glog[$];
  logic [7:0] wlog[$];

  typedef struct {
    logic          rst;
    logic          ini;
    logic [TW-1:0] thr;
    int            st;
    int            th;
  } vec_t;
  vec_t tv[6];

  int         exp_g2[3], exp_g3[8];
  logic [7:0] exp_w2[3], exp_w3[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    fm[i][fc[i]] = d;
    fc[i]++;
  endtask

  task automatic pop_q(input int i);
    for (int k = 0; k < 31; k++) fm[i][k] = fm[i][k+1];
    fc[i]--;
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NF; i++) begin
      fifo_empty[i] = (fc[i] == 0);
      fifo_data[i*BW +: BW] = (fc[i] != 0) ? fm[i][0] : 8'h00;
    end
  endtask

  // Grant rule: first non-empty FIFO scanning upward from the pointer.
  function automatic int model_grant();
    int start;
    if (mstate != M_ACTIVE || init || af) return -1;
`ifdef ARB_STRICT_PRIO_EN
    start = 0;
`else
    start = mptr;
`endif
    for (int k = 0; k < NF; k++)
      if (fc[(start + k) % NF] > 0) return (start + k) % NF;
    return -1;
  endfunction

  task automatic model_reset();
    mstate = M_RESET; mptr = 0; mwr = 1'b0; mdata = 8'h00; mthr = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at
  // the edge, then check registered outputs just after it.
  task automatic cycle();
    int  nstate;
    bit  any;
    drive_fifos();
    @(negedge clk);
    mgrant = model_grant();
    chk("fifo_rd", fifo_rd, (mgrant >= 0) ? (32'd1 << mgrant) : 32'd0);
    chk("state", state, mstate);
    chk("idle", idle, mstate == M_IDLE);
    chk("thr_out", thr_out, mthr);
    for (int i = 0; i < NF; i++) if (fifo_rd[i]) glog.push_back(i);
    any = 0;
    for (int i = 0; i < NF; i++) if (fc[i] > 0) any = 1;
    nstate = mstate;
    case (mstate)
      M_RESET:  nstate = M_INIT;
      M_INIT:   begin mthr = thr_in; if (!init) nstate = M_IDLE; end
      M_IDLE:   if (init) nstate = M_INIT; else if (any) nstate = M_ACTIVE;
      default:  if (init) nstate = M_INIT; else if (!any && mgrant < 0) nstate = M_IDLE;
    endcase
    @(posedge clk); #1;
    mwr = (mgrant >= 0);
    if (mwr) begin
      mdata = fm[mgrant][0];
      pop_q(mgrant);
      mptr = (mgrant + 1) % NF;
    end
    mstate = nstate;
    chk("out_wr", out_wr, mwr);
    chk("out_data", out_data, mdata);
    if (out_wr) begin wlog.push_back(out_data); run++; if (run > maxrun) maxrun = run; end
    else run = 0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any edge.
  task automatic async_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_wr", out_wr, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_state", state, M_RESET);
    chk("rst_thr", thr_out, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic bringup(input logic [TW-1:0] t);
    init = 1'b1; thr_in = t;
    cycle(); cycle();
    init = 1'b0;
    cycle();
  endtask

  task automatic fill_all();
    for (int i = 0; i < NF; i++)
      for (int j = 0; j < 2; j++) push(i, 8'((i + 1) * 16 + j));
  endtask

  task automatic clear_logs();
    glog.delete(); wlog.delete(); run = 0; maxrun = 0;
  endtask

  task automatic check_g3(input string tag);
    chk({tag, "_npop"}, glog.size(), 8);
    chk({tag, "_nwr"}, wlog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < glog.size()) chk({tag, "_grant"}, glog[k], exp_g3[k]);
      if (k < wlog.size()) chk({tag, "_data"}, wlog[k], exp_w3[k]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NF; i++) fc[i] = 0;
    model_reset();
    run = 0; maxrun = 0;

    // Expected orders
`ifdef ARB_STRICT_PRIO_EN
    exp_g2 = '{0, 0, 2};
    exp_w2 = '{8'hA1, 8'hB2, 8'hC3};
    exp_g3 = '{0, 0, 1, 1, 2, 2, 3, 3};
    exp_w3 = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41};
`else
    exp_g2 = '{0, 2, 0};
    exp_w2 = '{8'hA1, 8'hC3, 8'hB2};
    exp_g3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_w3 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 8'h21, 8'h31, 8'h41};
`endif

    // Reset / init sequence: inputs held for one edge, outputs sampled after.
    tv[0] = '{1'b0, 1'b0, 3'd0, M_RESET, 0};
    tv[1] = '{1'b0, 1'b0, 3'd0, M_RESET, 0};
    tv[2] = '{1'b1, 1'b1, 3'd5, M_INIT,  0};
    tv[3] = '{1'b1, 1'b1, 3'd5, M_INIT,  5};
    tv[4] = '{1'b1, 1'b0, 3'd5, M_IDLE,  5};
    tv[5] = '{1'b1, 1'b0, 3'd2, M_IDLE,  5};
    drive_fifos();
    #1;
    chk("por_state", state, M_RESET);
    chk("por_out_wr", out_wr, 0);
    for (int v = 0; v < 6; v++) begin
      reset = tv[v].rst; init = tv[v].ini; thr_in = tv[v].thr;
      @(posedge clk); #1;
      chk("tv_state", state, tv[v].st);
      chk("tv_thr", thr_out, tv[v].th);
      chk("tv_idle", idle, tv[v].st == M_IDLE);
      chk("tv_out_wr", out_wr, 0);
      chk("tv_fifo_rd", fifo_rd, 0);
    end
    mstate = M_IDLE; mthr = 3'd5;

    // Sparse occupancy: FIFO0 {A,B}, FIFO2 {C}
    clear_logs();
    push(0, 8'hA1); push(0, 8'hB2); push(2, 8'hC3);
    for (int c = 0; c < 8; c++) cycle();
    chk("t2_npop", glog.size(), 3);
    chk("t2_nwr", wlog.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < glog.size()) chk("t2_grant", glog[k], exp_g2[k]);
      if (k < wlog.size()) chk("t2_data", wlog[k], exp_w2[k]);
    end
    chk("t2_idle", state, M_IDLE);

    // All FIFOs two deep, from a fresh pointer
    async_reset(); bringup(3'd5);
    clear_logs();
    fill_all();
    for (int c = 0; c < 12; c++) cycle();
    check_g3("t3");
    chk("t3_run", maxrun, 8);

    // Back-pressure after three pops
    async_reset(); bringup(3'd3);
    clear_logs();
    fill_all();
    for (int c = 0; c < 4; c++) cycle();
    chk("t4_pops_before", glog.size(), 3);
    af = 1'b1;
    cycle();
    chk("t4_third_written", wlog.size(), 3);
    for (int c = 0; c < 3; c++) cycle();
    chk("t4_no_pop", glog.size(), 3);
    af = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    check_g3("t4");

    // Reset in the middle of a drain
    async_reset(); bringup(3'd1);
    clear_logs();
    fill_all();
    for (int c = 0; c < 4; c++) cycle();
    chk("t5_busy", out_wr, 1);
    async_reset(); bringup(3'd6);
    for (int c = 0; c < 12; c++) cycle();
    chk("t5_drained", state, M_IDLE);

    // init raised while popping
    fill_all();
    cycle(); cycle();
    init = 1'b1;
    cycle();
    init = 1'b0;
    for (int c = 0; c < 14; c++) cycle();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NF; i++)
        if ($urandom_range(0, 3) == 0 && fc[i] < 30) push(i, 8'($urandom));
      af = ($urandom_range(0, 4) == 0);
      if (init) init = ($urandom_range(0, 1) == 0);
      else      init = ($urandom_range(0, 60) == 0);
      thr_in = TW'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        bringup(TW'($urandom));
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
